// File: rtl/dsa_fetch_unit_simd_if.sv
// Bus between the SIMD control FSM / source-image memory and the fetch unit.
interface dsa_fetch_unit_simd_if #(
  parameter int SIMD_WIDTH = 4,
  parameter int ADDR_WIDTH = 18
);
  logic                    fetch_req;
  logic [15:0]             current_x;
  logic [15:0]             current_y;
  logic [15:0]             img_width_in;
  logic [15:0]             img_height_in;
  logic [15:0]             img_width_out;
  logic [15:0]             scale_x;
  logic [15:0]             scale_y;
  logic                    mem_rd;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [7:0]              mem_rdata;
  logic [8*SIMD_WIDTH-1:0] p00_flat;
  logic [8*SIMD_WIDTH-1:0] p01_flat;
  logic [8*SIMD_WIDTH-1:0] p10_flat;
  logic [8*SIMD_WIDTH-1:0] p11_flat;
  logic [8*SIMD_WIDTH-1:0] frac_x_flat;
  logic [7:0]              frac_y;
  logic [SIMD_WIDTH-1:0]   lane_valid;
  logic                    fetch_done;
  logic                    busy;

  modport slave (
    input  fetch_req, current_x, current_y, img_width_in, img_height_in,
           img_width_out, scale_x, scale_y, mem_rdata,
    output mem_rd, mem_addr, p00_flat, p01_flat, p10_flat, p11_flat,
           frac_x_flat, frac_y, lane_valid, fetch_done, busy
  );

  modport master (
    output fetch_req, current_x, current_y, img_width_in, img_height_in,
           img_width_out, scale_x, scale_y, mem_rdata,
    input  mem_rd, mem_addr, p00_flat, p01_flat, p10_flat, p11_flat,
           frac_x_flat, frac_y, lane_valid, fetch_done, busy
  );
endinterface

// File: rtl/dsa_fetch_unit_simd.sv
// Source-pixel fetch for the SIMD bilinear datapath: per-lane coordinate
// mapping and clamping, then a lane-major 4-neighbour read burst from a
// single-port memory into held output registers.

// One lane's x mapping: Q8.8 source position, clamped neighbour columns,
// weight and validity against the output width.
module dsa_fetch_unit_simd_lane #(
  parameter int LANE      = 0,
  parameter int FRAC_BITS = 8
) (
  input  logic [15:0] i_cur_x,
  input  logic [15:0] i_scale,
  input  logic [15:0] i_max,
  input  logic [15:0] i_w_out,
  output logic [15:0] o_c0,
  output logic [15:0] o_c1,
  output logic [7:0]  o_frac,
  output logic        o_valid
);
  logic [16:0]          w_pos;
  logic [31:0]          w_src;
  logic [31-FRAC_BITS:0] w_raw;
  logic [16:0]          w_c0p1;

  assign w_pos   = {1'b0, i_cur_x} + 17'(LANE);
  assign w_src   = 32'(w_pos) * {16'b0, i_scale};
  assign w_raw   = w_src[31:FRAC_BITS];
  assign o_c0    = (w_raw > (32-FRAC_BITS)'(i_max)) ? i_max : w_raw[15:0];
  assign w_c0p1  = {1'b0, o_c0} + 17'd1;
  assign o_c1    = (w_c0p1 > {1'b0, i_max}) ? i_max : w_c0p1[15:0];
  assign o_frac  = w_src[FRAC_BITS-1:0];
  assign o_valid = w_pos < {1'b0, i_w_out};
endmodule

module dsa_fetch_unit_simd #(
  parameter int SIMD_WIDTH = 4,
  parameter int ADDR_WIDTH = 18,
  parameter int FRAC_BITS  = 8
) (
  input logic clk,
  input logic rst,
  dsa_fetch_unit_simd_if.slave bus
);
  localparam int NRD   = 4 * SIMD_WIDTH;
  localparam int IDX_W = $clog2(NRD);

  typedef enum logic [2:0] {IDLE, CALC, READ, DRAIN, DONE} state_t;
  state_t r_state;

  // zero-sized source dimensions behave as one pixel
  logic [15:0] w_win, w_wm1, w_hm1;
  assign w_win = (bus.img_width_in == 16'd0) ? 16'd1 : bus.img_width_in;
  assign w_wm1 = w_win - 16'd1;
  assign w_hm1 = (bus.img_height_in == 16'd0) ? 16'd0 : bus.img_height_in - 16'd1;

  logic [SIMD_WIDTH-1:0][15:0] w_x0, w_x1;
  logic [SIMD_WIDTH-1:0][7:0]  w_fx;
  logic [SIMD_WIDTH-1:0]       w_lv;

  for (genvar g = 0; g < SIMD_WIDTH; g++) begin : g_lane
    dsa_fetch_unit_simd_lane #(.LANE(g), .FRAC_BITS(FRAC_BITS)) u_lane (
      .i_cur_x (bus.current_x),
      .i_scale (bus.scale_x),
      .i_max   (w_wm1),
      .i_w_out (bus.img_width_out),
      .o_c0    (w_x0[g]),
      .o_c1    (w_x1[g]),
      .o_frac  (w_fx[g]),
      .o_valid (w_lv[g])
    );
  end

  // shared row mapping
  logic [31:0]           w_src_y;
  logic [31-FRAC_BITS:0] w_y_raw;
  logic [15:0]           w_y0, w_y1;
  logic [16:0]           w_y0p1;
  assign w_src_y = {16'b0, bus.current_y} * {16'b0, bus.scale_y};
  assign w_y_raw = w_src_y[31:FRAC_BITS];
  assign w_y0    = (w_y_raw > (32-FRAC_BITS)'(w_hm1)) ? w_hm1 : w_y_raw[15:0];
  assign w_y0p1  = {1'b0, w_y0} + 17'd1;
  assign w_y1    = (w_y0p1 > {1'b0, w_hm1}) ? w_hm1 : w_y0p1[15:0];

  logic [SIMD_WIDTH-1:0][15:0]      r_x0, r_x1;
  logic [15:0]                      r_y0, r_y1, r_win;
  logic [IDX_W-1:0]                 r_idx, r_idx_d;
  logic                             r_cap_vld;
  logic                             r_mem_rd;
  logic [ADDR_WIDTH-1:0]            r_mem_addr;
  logic [3:0][SIMD_WIDTH-1:0][7:0]  r_pix;
  logic [SIMD_WIDTH-1:0][7:0]       r_fx;
  logic [7:0]                       r_fy;
  logic [SIMD_WIDTH-1:0]            r_lv;
  logic                             r_done, r_busy;

  // first burst address straight from the mapping logic, so mem_rd can be
  // registered without a bubble after CALC
  logic [31:0] w_addr_first;
  assign w_addr_first = {16'b0, w_y0} * {16'b0, w_win} + {16'b0, w_x0[0]};

  // address of the next read in the burst: slot k of a lane picks x1 for
  // odd k (right neighbour) and y1 for k>=2 (lower neighbour)
  logic [IDX_W-1:0] w_nidx;
  logic [15:0]      w_sel_x, w_sel_y;
  logic [31:0]      w_addr_next;
  assign w_nidx = r_idx + IDX_W'(1);

  // select coordinates for the next read slot
  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int l = 0; l < SIMD_WIDTH; l++)
      for (int k = 0; k < 4; k++)
        if (w_nidx == IDX_W'(4*l + k)) begin
          w_sel_x = ((k & 1) != 0) ? r_x1[l] : r_x0[l];
          w_sel_y = ((k & 2) != 0) ? r_y1 : r_y0;
        end
  end
  assign w_addr_next = {16'b0, w_sel_y} * {16'b0, r_win} + {16'b0, w_sel_x};

  // control FSM, read burst and capture of returning bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_win      <= '0;
      r_idx      <= '0;
      r_idx_d    <= '0;
      r_cap_vld  <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_pix      <= '0;
      r_fx       <= '0;
      r_fy       <= '0;
      r_lv       <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cap_vld <= r_mem_rd;
      r_idx_d   <= r_idx;
      if (r_cap_vld)
        for (int l = 0; l < SIMD_WIDTH; l++)
          for (int k = 0; k < 4; k++)
            if (r_idx_d == IDX_W'(4*l + k)) r_pix[k][l] <= bus.mem_rdata;
      case (r_state)
        IDLE: if (bus.fetch_req) begin
          r_state <= CALC;
          r_busy  <= 1'b1;
        end
        CALC: begin
          r_x0       <= w_x0;
          r_x1       <= w_x1;
          r_y0       <= w_y0;
          r_y1       <= w_y1;
          r_win      <= w_win;
          r_fx       <= w_fx;
          r_fy       <= w_src_y[FRAC_BITS-1:0];
          r_lv       <= w_lv;
          r_idx      <= '0;
          r_mem_rd   <= 1'b1;
          r_mem_addr <= ADDR_WIDTH'(w_addr_first);
          r_state    <= READ;
        end
        READ: begin
          if (r_idx == IDX_W'(NRD - 1)) begin
            r_mem_rd <= 1'b0;
            r_state  <= DRAIN;
          end else begin
            r_idx      <= w_nidx;
            r_mem_addr <= ADDR_WIDTH'(w_addr_next);
          end
        end
        DRAIN: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd      = r_mem_rd;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.p00_flat    = r_pix[0];
  assign bus.p01_flat    = r_pix[1];
  assign bus.p10_flat    = r_pix[2];
  assign bus.p11_flat    = r_pix[3];
  assign bus.frac_x_flat = r_fx;
  assign bus.frac_y      = r_fy;
  assign bus.lane_valid  = r_lv;
  assign bus.fetch_done  = r_done;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_dsa_fetch_unit_simd.sv
// Directed bench for dsa_fetch_unit_simd: 8x8 source image with pixel = address.
module tb_dsa_fetch_unit_simd;
  localparam int SW = 4;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] mem [0:255];

  dsa_fetch_unit_simd_if #(.SIMD_WIDTH(SW), .ADDR_WIDTH(AW)) bus();

  dsa_fetch_unit_simd #(.SIMD_WIDTH(SW), .ADDR_WIDTH(AW), .FRAC_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // synchronous-read source memory: data valid the cycle after mem_rd
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[7:0]];

  // Request at negedge; c counts posedges from (and including) the sampling
  // edge, observed at the following negedge. fetch_req is re-pulsed at c==retrig.
  task automatic run_fetch(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] sx, input logic [15:0] sy,
                           input int retrig,
                           output int lat, output int nrd, output int ndone);
    @(negedge clk);
    bus.current_x = x;  bus.current_y = y;
    bus.scale_x   = sx; bus.scale_y   = sy;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    lat = 0; nrd = 0; ndone = 0;
    for (int c = 1; c <= 30; c++) begin
      if (bus.mem_rd) nrd++;
      if (bus.fetch_done) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      bus.fetch_req = (c == retrig);
      @(negedge clk);
    end
    bus.fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.mem_rd !== 1'b0) $display("FAIL reset_mem_rd got %0b want 0", bus.mem_rd); else n_pass++;
    n_total++; if (bus.fetch_done !== 1'b0) $display("FAIL reset_done got %0b want 0", bus.fetch_done); else n_pass++;
    n_total++; if (bus.p00_flat !== 32'h0) $display("FAIL reset_p00 got %h want 0", bus.p00_flat); else n_pass++;
    n_total++; if (bus.lane_valid !== 4'h0) $display("FAIL reset_lane_valid got %b want 0000", bus.lane_valid); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %0b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_identity();
    int lat, nrd, nd;
    run_fetch(16'd0, 16'd0, 16'h0100, 16'h0100, 0, lat, nrd, nd);
    n_total++; if (bus.p00_flat !== 32'h03020100) $display("FAIL id_p00 got %h want 03020100", bus.p00_flat); else n_pass++;
    n_total++; if (bus.p01_flat !== 32'h04030201) $display("FAIL id_p01 got %h want 04030201", bus.p01_flat); else n_pass++;
    n_total++; if (bus.p10_flat !== 32'h0B0A0908) $display("FAIL id_p10 got %h want 0b0a0908", bus.p10_flat); else n_pass++;
    n_total++; if (bus.p11_flat !== 32'h0C0B0A09) $display("FAIL id_p11 got %h want 0c0b0a09", bus.p11_flat); else n_pass++;
    n_total++; if (bus.frac_x_flat !== 32'h0) $display("FAIL id_frac_x got %h want 0", bus.frac_x_flat); else n_pass++;
    n_total++; if (bus.frac_y !== 8'h0) $display("FAIL id_frac_y got %h want 0", bus.frac_y); else n_pass++;
    n_total++; if (bus.lane_valid !== 4'hF) $display("FAIL id_lane_valid got %b want 1111", bus.lane_valid); else n_pass++;
    n_total++; if (lat !== 19) $display("FAIL id_latency got %0d want 19", lat); else n_pass++;
    n_total++; if (nrd !== 16) $display("FAIL id_reads got %0d want 16", nrd); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL id_done_count got %0d want 1", nd); else n_pass++;
  endtask

  task automatic test_upscale();
    int lat, nrd, nd;
    run_fetch(16'd0, 16'd1, 16'h0080, 16'h0080, 0, lat, nrd, nd);
    n_total++; if (bus.p00_flat !== 32'h01010000) $display("FAIL up_p00 got %h want 01010000", bus.p00_flat); else n_pass++;
    n_total++; if (bus.p01_flat !== 32'h02020101) $display("FAIL up_p01 got %h want 02020101", bus.p01_flat); else n_pass++;
    n_total++; if (bus.p10_flat !== 32'h09090808) $display("FAIL up_p10 got %h want 09090808", bus.p10_flat); else n_pass++;
    n_total++; if (bus.p11_flat !== 32'h0A0A0909) $display("FAIL up_p11 got %h want 0a0a0909", bus.p11_flat); else n_pass++;
    n_total++; if (bus.frac_x_flat !== 32'h80008000) $display("FAIL up_frac_x got %h want 80008000", bus.frac_x_flat); else n_pass++;
    n_total++; if (bus.frac_y !== 8'h80) $display("FAIL up_frac_y got %h want 80", bus.frac_y); else n_pass++;
  endtask

  task automatic test_right_edge();
    int lat, nrd, nd;
    run_fetch(16'd6, 16'd0, 16'h0100, 16'h0100, 0, lat, nrd, nd);
    n_total++; if (bus.p00_flat !== 32'h07070706) $display("FAIL re_p00 got %h want 07070706", bus.p00_flat); else n_pass++;
    n_total++; if (bus.p01_flat !== 32'h07070707) $display("FAIL re_p01 got %h want 07070707", bus.p01_flat); else n_pass++;
    n_total++; if (bus.p10_flat !== 32'h0F0F0F0E) $display("FAIL re_p10 got %h want 0f0f0f0e", bus.p10_flat); else n_pass++;
    n_total++; if (bus.p11_flat !== 32'h0F0F0F0F) $display("FAIL re_p11 got %h want 0f0f0f0f", bus.p11_flat); else n_pass++;
    n_total++; if (bus.lane_valid !== 4'b0011) $display("FAIL re_lane_valid got %b want 0011", bus.lane_valid); else n_pass++;
    n_total++; if (nrd !== 16) $display("FAIL re_reads got %0d want 16", nrd); else n_pass++;
  endtask

  task automatic test_bottom_edge();
    int lat, nrd, nd;
    run_fetch(16'd0, 16'd7, 16'h0100, 16'h0100, 0, lat, nrd, nd);
    n_total++; if (bus.p00_flat !== 32'h3B3A3938) $display("FAIL be_p00 got %h want 3b3a3938", bus.p00_flat); else n_pass++;
    n_total++; if (bus.p01_flat !== 32'h3C3B3A39) $display("FAIL be_p01 got %h want 3c3b3a39", bus.p01_flat); else n_pass++;
    n_total++; if (bus.p10_flat !== 32'h3B3A3938) $display("FAIL be_p10 got %h want 3b3a3938", bus.p10_flat); else n_pass++;
    n_total++; if (bus.p11_flat !== 32'h3C3B3A39) $display("FAIL be_p11 got %h want 3c3b3a39", bus.p11_flat); else n_pass++;
  endtask

  task automatic test_retrigger_hold();
    int lat, nrd, nd, nd_hold;
    run_fetch(16'd0, 16'd0, 16'h0100, 16'h0100, 5, lat, nrd, nd);
    n_total++; if (nrd !== 16) $display("FAIL rt_reads got %0d want 16", nrd); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL rt_done_count got %0d want 1", nd); else n_pass++;
    n_total++; if (lat !== 19) $display("FAIL rt_latency got %0d want 19", lat); else n_pass++;
    // scale/position changes outside CALC must not disturb the held group
    bus.scale_x = 16'h0200; bus.current_x = 16'd3;
    nd_hold = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.fetch_done) nd_hold++;
    end
    n_total++; if (bus.p00_flat !== 32'h03020100) $display("FAIL hold_p00 got %h want 03020100", bus.p00_flat); else n_pass++;
    n_total++; if (bus.p11_flat !== 32'h0C0B0A09) $display("FAIL hold_p11 got %h want 0c0b0a09", bus.p11_flat); else n_pass++;
    n_total++; if (bus.frac_x_flat !== 32'h0) $display("FAIL hold_frac_x got %h want 0", bus.frac_x_flat); else n_pass++;
    n_total++; if (bus.lane_valid !== 4'hF) $display("FAIL hold_lane_valid got %b want 1111", bus.lane_valid); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL hold_busy got %0b want 0", bus.busy); else n_pass++;
    n_total++; if (nd_hold !== 0) $display("FAIL hold_done_count got %0d want 0", nd_hold); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, nrd, nd, nd_abort;
    @(negedge clk);
    bus.current_x = 16'd0; bus.current_y = 16'd1;
    bus.scale_x = 16'h0100; bus.scale_y = 16'h0100;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    // c=1 is CALC, c=2 is the first READ cycle; reset in the fifth
    for (int c = 1; c < 6; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rm_busy got %0b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.mem_rd !== 1'b0) $display("FAIL rm_mem_rd got %0b want 0", bus.mem_rd); else n_pass++;
    n_total++; if (bus.p00_flat !== 32'h0) $display("FAIL rm_p00 got %h want 0", bus.p00_flat); else n_pass++;
    n_total++; if (bus.p11_flat !== 32'h0) $display("FAIL rm_p11 got %h want 0", bus.p11_flat); else n_pass++;
    n_total++; if (bus.lane_valid !== 4'h0) $display("FAIL rm_lane_valid got %b want 0000", bus.lane_valid); else n_pass++;
    n_total++; if (bus.frac_y !== 8'h0) $display("FAIL rm_frac_y got %h want 0", bus.frac_y); else n_pass++;
    nd_abort = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.fetch_done) nd_abort++;
      @(negedge clk);
    end
    n_total++; if (nd_abort !== 0) $display("FAIL rm_no_done got %0d want 0", nd_abort); else n_pass++;
    run_fetch(16'd0, 16'd1, 16'h0100, 16'h0100, 0, lat, nrd, nd);
    n_total++; if (bus.p00_flat !== 32'h0B0A0908) $display("FAIL rm_new_p00 got %h want 0b0a0908", bus.p00_flat); else n_pass++;
    n_total++; if (bus.p11_flat !== 32'h14131211) $display("FAIL rm_new_p11 got %h want 14131211", bus.p11_flat); else n_pass++;
    n_total++; if (nrd !== 16) $display("FAIL rm_new_reads got %0d want 16", nrd); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL rm_new_done got %0d want 1", nd); else n_pass++;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    bus.fetch_req     = 1'b0;
    bus.current_x     = 16'd0;
    bus.current_y     = 16'd0;
    bus.img_width_in  = 16'd8;
    bus.img_height_in = 16'd8;
    bus.img_width_out = 16'd8;
    bus.scale_x       = 16'h0100;
    bus.scale_y       = 16'h0100;
    bus.mem_rdata     = 8'h00;
    test_reset();
    test_identity();
    test_upscale();
    test_right_edge();
    test_bottom_edge();
    test_retrigger_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dsa_fetch_unit_simd.md
Name: dsa_fetch_unit_simd

Overview:
- Source-pixel fetch stage directly upstream of the SIMD bilinear datapath; driven by the SIMD control FSM through fetch_req/fetch_done.
- For the output group at (current_x..current_x+SIMD_WIDTH-1, current_y), maps each lane to source coordinates with Q8.8 scale factors.
- Reads the four neighbours of each lane from a single-port source-image memory and presents them, with fractional weights, as stable registered outputs.

Parameters:
SIMD_WIDTH, 4, lanes per group (1..8)
ADDR_WIDTH, 18, source memory address width
FRAC_BITS, 8, fractional bits of scale factors and weights (fixed 8)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
fetch_req  in  1  one-cycle start pulse
current_x  in  16  output x of lane 0
current_y  in  16  output row
img_width_in  in  16  source width W_in
img_height_in  in  16  source height H_in
img_width_out  in  16  output width, for lane validity
scale_x  in  16  Q8.8 source step per output pixel in x
scale_y  in  16  Q8.8 source step per output row
mem_rd  out  1  read strobe
mem_addr  out  ADDR_WIDTH  read address
mem_rdata  in  8  read data, valid the cycle after mem_rd
p00_flat,p01_flat,p10_flat,p11_flat  out  8*SIMD_WIDTH  neighbour pixels (TL,TR,BL,BR); lane i at bits [8i+7:8i]
frac_x_flat  out  8*SIMD_WIDTH  per-lane x weight
frac_y  out  8  shared y weight
lane_valid  out  SIMD_WIDTH  bit i = (current_x+i < img_width_out)
fetch_done  out  1  one-cycle completion pulse
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset mid-operation aborts immediately. No fetch_done is issued for the aborted request.
- States: IDLE -> CALC -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: samples fetch_req. If it is 1, the next state is CALC.
- CALC (1 cycle):
  - src_x_i = (current_x+i)*scale_x, 32-bit. x0 = src_x_i>>8; frac_x_i = src_x_i[7:0].
  - Same for y: y0 = src_y>>8; frac_y = src_y[7:0].
  - Clamp: x0 = min(x0, W_in-1); x1 = min(x0+1, W_in-1). y0 and y1 are clamped the same way against H_in-1.
  - Fractions are not modified by clamping.
  - W_in or H_in of 0 is treated as 1.
  - Latch lane_valid and frac outputs.
- READ (4*SIMD_WIDTH cycles):
  - mem_rd=1 every cycle.
  - Order is lane-major: lane0 p00,p01,p10,p11, then lane1, and so on.
  - addr = y*W_in + x, computed at full width and truncated to ADDR_WIDTH.
  - Each returning byte is written into its slot using a one-cycle-delayed read index.
- DRAIN (1 cycle): mem_rd=0; captures the last byte.
- DONE (1 cycle): fetch_done=1, then IDLE.
- Latency: fetch_req sampled at edge k → fetch_done high during cycle k+3+4*SIMD_WIDTH (19 cycles for SIMD_WIDTH=4). Exactly 4*SIMD_WIDTH reads per request.
- Holding: data, frac and lane_valid outputs are held from DONE until the next CALC. They are stable while the datapath interpolates.
- fetch_req while busy: ignored, no queuing.
- Invalid lanes are still read at clamped, legal addresses, so timing is fixed. Downstream masks them with lane_valid.
- Scale values are sampled only in CALC; changes at other times have no effect.

Test Plan:
- Identity (scale 0x0100), 8x8 source with pixel = address, current (0,0), W_out=8:
  - p00 lanes = 0,1,2,3; p01 = 1,2,3,4; p10 = 8..11; p11 = 9..12.
  - All fracs 0; lane_valid = 1111.
  - fetch_done 19 cycles after request; exactly 16 mem_rd pulses.
- 2x upscale (scale 0x0080), current (0,1):
  - x0 = 0,0,1,1; frac_x = 0,128,0,128.
  - y0=0, y1=1, frac_y=128.
  - p00 lanes = 0,0,1,1.
- Right edge, identity, current_x=6, W_in=W_out=8:
  - lane1: p00=p01=7.
  - lanes 2,3 clamped to x=7.
  - lane_valid = 0011.
- Bottom edge, identity, current_y=7, H_in=8: y1 clamped to 7; p10 == p00 and p11 == p01 for every lane.
- Assert fetch_req again during READ: ignored; exactly 16 reads and one fetch_done. Outputs stay stable for 10 cycles after DONE with no request.
- Assert rst during READ cycle 5, then release:
  - All outputs 0, busy=0, no fetch_done.
  - A new request completes normally with correct data.
